// File: rtl/load_scoreboard.sv
// Busy-register scoreboard for in-flight loads; busy/outstanding update on the edge after issue/response.
// Backpressure: stall is combinational from registered state and the D bundle; issue is gated by ~stall.
module load_scoreboard #(
  parameter int MAX_OUT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs1D1,
  input  logic [4:0]  rs2D1,
  input  logic [4:0]  rs1D2,
  input  logic [4:0]  rs2D2,
  input  logic [4:0]  rdD1,
  input  logic [4:0]  rdD2,
  input  logic        loadD1,
  input  logic        loadD2,
  input  logic        issue,
  input  logic        resp_valid,
  input  logic [4:0]  resp_rd,
  output logic        stall,
  output logic [31:0] busy,
  output logic [3:0]  outstanding,
  output logic        sb_err
);

  logic [31:1] busy_q;
  logic [31:1] busy_d;
  logic [3:0]  cnt_q;
  logic [3:0]  cnt_d;
  logic        err_q;
  logic [31:0] busy_v;
  logic        raw_hit;
  logic        waw_hit;
  logic        dbl_hit;
  logic        budget_hit;
  logic [4:0]  need;
  logic [4:0]  sum;
  logic        go;
  logic        set1;
  logic        set2;
  logic        dec;
  logic        err_d;

  assign busy_v = {busy_q, 1'b0};

  // busy_v[0] is tied low, so x0 never produces a hit
  assign raw_hit    = busy_v[rs1D1] | busy_v[rs2D1] | busy_v[rs1D2] | busy_v[rs2D2];
  assign waw_hit    = (loadD1 & busy_v[rdD1]) | (loadD2 & busy_v[rdD2]);
  assign dbl_hit    = loadD1 & loadD2 & (rdD1 == rdD2) & (rdD1 != 5'd0);
  assign need       = {1'b0, cnt_q} + 5'(loadD1) + 5'(loadD2);
  assign budget_hit = need > 5'(MAX_OUT);
  assign stall      = raw_hit | waw_hit | dbl_hit | budget_hit;

  assign go   = issue & ~stall;
  assign set1 = go & loadD1;
  assign set2 = go & loadD2;

  // Set takes priority over a same-cycle clear of the same register
  always_comb begin
    busy_d = '0;
    for (int i = 1; i < 32; i++) begin
      busy_d[i] = (set1 && (rdD1 == 5'(i))) ||
                  (set2 && (rdD2 == 5'(i))) ||
                  (busy_q[i] && !(resp_valid && (resp_rd == 5'(i))));
    end
  end

  // A response with nothing counted (e.g. pre-reset load) saturates at zero
  assign sum   = {1'b0, cnt_q} + 5'(set1) + 5'(set2);
  assign dec   = resp_valid && (sum != 5'd0);
  assign cnt_d = 4'(sum - 5'(dec));

  assign err_d = err_q |
                 (resp_valid & (((resp_rd != 5'd0) & ~busy_v[resp_rd]) | (cnt_q == 4'd0)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign busy        = busy_v;
  assign outstanding = cnt_q;
  assign sb_err      = err_q;

endmodule

// File: tb/tb_load_scoreboard.sv
// Bench for load_scoreboard: directed vector table, hand sequences, and random traffic vs a reference model.
module tb_load_scoreboard;
  localparam int MAXO = 4;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs1D1, rs2D1, rs1D2, rs2D2, rdD1, rdD2, resp_rd;
  logic        loadD1, loadD2, issue, resp_valid;
  logic        stall, sb_err;
  logic [31:0] busy;
  logic [3:0]  outstanding;

  load_scoreboard #(.MAX_OUT(MAXO)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1D1(rs1D1), .rs2D1(rs2D1), .rs1D2(rs1D2), .rs2D2(rs2D2),
    .rdD1(rdD1), .rdD2(rdD2), .loadD1(loadD1), .loadD2(loadD2),
    .issue(issue), .resp_valid(resp_valid), .resp_rd(resp_rd),
    .stall(stall), .busy(busy), .outstanding(outstanding), .sb_err(sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rs1a, rs2a, rs1b, rs2b, rda, rdb;
    logic        lda, ldb, iss, rv;
    logic [4:0]  rrd;
    logic        e_stall;
    logic [31:0] e_busy;
    logic [3:0]  e_out;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  // Reference model: set of busy registers plus an arithmetic in-flight count
  bit   m_busy[32];
  int   m_cnt;
  bit   m_err;
  logic [4:0] pend[$];
  bit   use_pend;
  int   rsp_idx;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [31:0] m_vec();
    logic [31:0] v = '0;
    for (int r = 1; r < 32; r++) v[r] = m_busy[r];
    return v;
  endfunction

  function automatic bit m_stall();
    bit s = 0;
    logic [4:0] srcs[4];
    srcs[0] = rs1D1; srcs[1] = rs2D1; srcs[2] = rs1D2; srcs[3] = rs2D2;
    foreach (srcs[k]) if (srcs[k] != 0 && m_busy[srcs[k]]) s = 1;
    if (loadD1 && rdD1 != 0 && m_busy[rdD1]) s = 1;
    if (loadD2 && rdD2 != 0 && m_busy[rdD2]) s = 1;
    if (loadD1 && loadD2 && rdD1 == rdD2 && rdD1 != 0) s = 1;
    if (m_cnt + int'(loadD1) + int'(loadD2) > MAXO) s = 1;
    return s;
  endfunction

  task automatic m_reset();
    foreach (m_busy[r]) m_busy[r] = 0;
    m_cnt = 0;
    m_err = 0;
    pend.delete();
  endtask

  task automatic drive(input logic [4:0] a1, a2, b1, b2, ra, rb,
                       input logic la, lb, is, v, input logic [4:0] rr);
    rs1D1 = a1; rs2D1 = a2; rs1D2 = b1; rs2D2 = b2; rdD1 = ra; rdD2 = rb;
    loadD1 = la; loadD2 = lb; issue = is; resp_valid = v; resp_rd = rr;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic observe(input string tag);
    @(negedge clk);
    chk({tag, "_stall"}, 32'(stall), 32'(m_stall()));
    chk({tag, "_busy"}, busy, m_vec());
    chk({tag, "_out"}, 32'(outstanding), 32'(m_cnt));
    chk({tag, "_err"}, 32'(sb_err), 32'(m_err));
  endtask

  task automatic advance();
    bit go;
    int sets;
    @(posedge clk);
    go = issue && !m_stall();
    if (resp_valid) begin
      if (m_cnt == 0 || (resp_rd != 0 && !m_busy[resp_rd])) m_err = 1;
      if (resp_rd != 0) m_busy[resp_rd] = 0;
      if (use_pend) pend.delete(rsp_idx);
    end
    sets = 0;
    if (go && loadD1) begin sets++; if (rdD1 != 0) m_busy[rdD1] = 1; pend.push_back(rdD1); end
    if (go && loadD2) begin sets++; if (rdD2 != 0) m_busy[rdD2] = 1; pend.push_back(rdD2); end
    m_cnt = m_cnt + sets - int'(resp_valid);
    if (m_cnt < 0) m_cnt = 0;
    #1;
  endtask

  task automatic add(input logic [4:0] a1, a2, b1, b2, ra, rb,
                     input logic la, lb, is, v, input logic [4:0] rr,
                     input logic es, input logic [31:0] eb, input logic [3:0] eo, input logic ee);
    vec_t t;
    t.rs1a = a1; t.rs2a = a2; t.rs1b = b1; t.rs2b = b2; t.rda = ra; t.rdb = rb;
    t.lda = la; t.ldb = lb; t.iss = is; t.rv = v; t.rrd = rr;
    t.e_stall = es; t.e_busy = eb; t.e_out = eo; t.e_err = ee;
    tbl.push_back(t);
  endtask

  initial begin
    use_pend = 0;
    rsp_idx  = 0;
    m_reset();
    //   rs1a rs2a rs1b rs2b rda rdb lda ldb iss rv rrd | stall busy out err
    add(0, 0, 0, 0, 5, 0, 1, 0, 1, 0, 0,   0, 32'h0,   0, 0);  // load x5
    add(5, 0, 0, 0, 10, 0, 0, 0, 1, 0, 0,  1, 32'h20,  1, 0);  // reader of x5
    add(5, 0, 0, 0, 10, 0, 0, 0, 1, 0, 0,  1, 32'h20,  1, 0);
    add(5, 0, 0, 0, 10, 0, 0, 0, 1, 1, 5,  1, 32'h20,  1, 0);  // response x5
    add(5, 0, 0, 0, 10, 0, 0, 0, 1, 0, 0,  0, 32'h0,   0, 0);
    add(0, 0, 0, 0, 6, 7, 1, 1, 1, 0, 0,   0, 32'h0,   0, 0);  // dual load
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 32'hC0,  2, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7,   0, 32'hC0,  2, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6,   0, 32'h40,  1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 32'h0,   0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0,   0, 32'h0,   0, 0);  // load x0
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 32'h0,   1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 32'h0,   1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 32'h0,   0, 0);
    add(0, 0, 0, 0, 5, 0, 1, 0, 1, 0, 0,   0, 32'h0,   0, 0);  // load x5
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 32'h20,  1, 0);
    add(0, 0, 0, 0, 5, 0, 1, 0, 1, 1, 5,   1, 32'h20,  1, 0);  // WAW vs returning x5
    add(0, 0, 0, 0, 5, 0, 1, 0, 1, 0, 0,   0, 32'h0,   0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 32'h20,  1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5,   0, 32'h20,  1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 32'h0,   0, 0);

    rst_n = 1'b0;
    nop();
    @(negedge clk);
    chk("rst_busy", busy, 32'h0);
    chk("rst_out", 32'(outstanding), 32'h0);
    chk("rst_err", 32'(sb_err), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      drive(tbl[i].rs1a, tbl[i].rs2a, tbl[i].rs1b, tbl[i].rs2b, tbl[i].rda, tbl[i].rdb,
            tbl[i].lda, tbl[i].ldb, tbl[i].iss, tbl[i].rv, tbl[i].rrd);
      observe("tbl");
      chk($sformatf("tbl%0d_stall", i), 32'(stall), 32'(tbl[i].e_stall));
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("tbl%0d_out", i), 32'(outstanding), 32'(tbl[i].e_out));
      chk($sformatf("tbl%0d_err", i), 32'(sb_err), 32'(tbl[i].e_err));
      advance();
    end

    // Budget: four loads in flight block a load bundle but not an ALU bundle
    drive(0, 0, 0, 0, 1, 2, 1, 1, 1, 0, 0); observe("full_a"); advance();
    drive(0, 0, 0, 0, 3, 4, 1, 1, 1, 0, 0); observe("full_b"); advance();
    drive(0, 0, 0, 0, 10, 0, 1, 0, 1, 0, 0); observe("full_c");
    chk("full_stall_load", 32'(stall), 32'h1);
    chk("full_out4", 32'(outstanding), 32'h4);
    advance();
    drive(11, 12, 0, 0, 8, 0, 0, 0, 1, 0, 0); observe("full_d");
    chk("full_add_go", 32'(stall), 32'h0);
    advance();
    drive(0, 0, 0, 0, 10, 0, 1, 0, 1, 1, 1); observe("full_e");
    chk("full_resp_cycle_stall", 32'(stall), 32'h1);
    advance();
    drive(0, 0, 0, 0, 10, 0, 1, 0, 1, 0, 0); observe("full_f");
    chk("full_unblock", 32'(stall), 32'h0);
    chk("full_out3", 32'(outstanding), 32'h3);
    advance();
    nop(); observe("full_g");
    chk("full_busy", busy, 32'h41C);
    advance();

    // Error on response to a non-busy register, sticky until async reset
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9); observe("err_a"); advance();
    nop(); observe("err_b");
    chk("err_set", 32'(sb_err), 32'h1);
    advance();
    observe("err_c");
    chk("err_held", 32'(sb_err), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 32'h0);
    chk("arst_out", 32'(outstanding), 32'h0);
    chk("arst_err", 32'(sb_err), 32'h0);
    m_reset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Response for a load issued before reset
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2); observe("stale_a"); advance();
    nop(); observe("stale_b");
    chk("stale_err", 32'(sb_err), 32'h1);
    chk("stale_out", 32'(outstanding), 32'h0);
    #2 rst_n = 1'b0;
    m_reset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    use_pend = 1;
    for (int c = 0; c < 600; c++) begin
      logic v;
      logic [4:0] rr;
      v = 0; rr = 0;
      if (pend.size() > 0 && $urandom_range(0, 2) == 0) begin
        rsp_idx = $urandom_range(0, pend.size() - 1);
        v  = 1;
        rr = pend[rsp_idx];
      end
      drive(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            $urandom_range(0, 4) < 2, $urandom_range(0, 4) < 2,
            $urandom_range(0, 3) != 0, v, rr);
      observe("rnd");
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/load_scoreboard.md
# load_scoreboard

Tracks outstanding load destinations in the dual-issue RV32I pipeline when data memory returns load results after a variable number of cycles. Each load's destination register is marked busy when the load issues from D and cleared when the memory response returns it. Decode is stalled while either issue slot reads or re-targets a busy register, or while the outstanding-load budget is exhausted. Sits beside the D/E boundary and is the release side of the load-use interlock.

## Interface
- MAX_OUT, default 4: maximum loads in flight (2..15).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- rs1D1, rs2D1, rs1D2, rs2D2  in  5 each  source registers of slot 1 and slot 2 in D.
- rdD1, rdD2  in  5 each  destination registers of the D slots.
- loadD1, loadD2  in  1 each  slot is a load with reg_write set.
- issue  in  1  D bundle advances to E this cycle; driven by the pipeline as (D valid & ~stall & ~other stall sources).
- resp_valid  in  1  a load result is written back this cycle.
- resp_rd  in  5  destination of that result.
- stall  out  1  hold D this cycle.
- busy  out  32  busy vector; bit 0 always 0.
- outstanding  out  4  loads in flight.
- sb_err  out  1  sticky: response for a non-busy register, or count underflow.

## Operation
- State: busy[31:1] flops, a 4-bit outstanding counter, the sb_err flop. busy[0] is constant 0.
- Set: on issue, for each slot with loadDn=1 and rdDn≠0, busy[rdDn]←1. The counter increments by the number of loading slots, including rd=0 loads, because memory still returns a response for them.
- Clear: on resp_valid with resp_rd≠0, busy[resp_rd]←0. The counter decrements by 1 on every resp_valid.
- Same-cycle set and clear of the same register: set wins.
- Counter update is count + sets − resp_valid in one cycle.
- stall=1 when any of the following holds:
  - any rs of either slot equals a nonzero register with busy=1 (RAW);
  - loadDn=1 and busy[rdDn]=1 (WAW, preserves in-order clear);
  - loadD1 & loadD2 & rdD1==rdD2 & rdD1≠0 (same-bundle double load to one register);
  - outstanding + loadD1 + loadD2 > MAX_OUT.
- stall is computed only from registered state. A response arriving this cycle does not unstall this cycle; it unstalls next cycle.
- Intra-bundle slot-2-reads-slot-1 dependencies are out of scope; the issue logic handles them.
- sb_err is set when resp_valid arrives with resp_rd≠0 and busy[resp_rd]=0, or with outstanding=0. It is cleared only by reset.
- On resp_valid with outstanding=0, the counter saturates at 0.
- issue with stall=1 is illegal. The block must still not set busy or count in that case; the issue is gated by ~stall internally.

## Timing
- Reset (async, while rst_n=0): busy=0, outstanding=0, sb_err=0, hence stall=0 unless the budget term applies (impossible at count 0 with MAX_OUT≥2).
- Reset mid-operation drops all tracking immediately. Responses arriving after reset for pre-reset loads set sb_err.
- Set latency: busy and outstanding change on the first rising edge after issue; stall reflects them in the same cycle they update.
- Clear latency: busy clears on the edge after resp_valid; stall drops the cycle after that response.
- Minimum load-to-dependent distance with a 1-cycle response: issue in cycle N, response in cycle N+1, dependent unstalled in cycle N+2.
- Full: outstanding=MAX_OUT stalls any load bundle, but non-load bundles with no RAW hit proceed.

## Test plan
- Load x5 issues in slot 1 at cycle 0; slot 1 of the next bundle reads rs1=x5. Required: stall=1 until the resp_rd=5 response at cycle 3, stall=0 at cycle 4; busy[5] is 1 for cycles 1–3.
- Both slots load (x6 and x7) in one bundle. Required: outstanding=2 and busy has bits 6,7 set next cycle; responses out of order (x7 then x6) clear each one independently.
- MAX_OUT=4 with four loads to x1..x4 in flight. Required: a new load bundle stalls while an ADD x8 bundle issues; one response makes outstanding=3 and unblocks the load the next cycle.
- Load x0 issues. Required: busy stays 0, outstanding=1; its response returns outstanding to 0 with sb_err=0.
- resp_valid with resp_rd=9 while busy[9]=0. Required: sb_err=1 and held; rst_n pulse low clears it asynchronously along with busy and outstanding.
- Same cycle: resp_valid for x5 and a new load to x5 issue (forced with stall=0 via a WAW-free setup, load previously to x5 now returning). Required: the WAW term blocks the issue; with the response done, the load issues next cycle and busy[5]=1 afterwards.
